midi_msg_parser: RTL

- Consumes the received-byte stream from the UART receive stage, which emits a one-cycle `byte_valid` strobe per byte at 31 250 or 115 200 baud.
- Assembles MIDI channel-voice messages, with running-status support, into decoded events: note-on, note-off, control-change and pitch-bend.
- Feeds the voice allocator and the control register block.
- One event at most per input byte, so no back-pressure exists.

---
 rtl/midi_pkg.sv | 32 +++
 rtl/midi_msg_parser.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the MIDI channel-voice message parser:
//   - status-nibble constants for the channel-voice message types
//   - parser state enumeration
//   - pitch-bend centre value
//   - helper classifying message types that carry a single data byte
// -----------------------------------------------------------------------------
package midi_pkg;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_POLY_AT  = 4'hA;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CH_AT    = 4'hD;
    localparam logic [3:0] ST_BEND     = 4'hE;

    localparam logic [13:0] BEND_CENTER = 14'd8192;

    typedef enum logic [1:0] {
        WAIT_STATUS = 2'd0,
        WAIT_D1     = 2'd1,
        WAIT_D2     = 2'd2
    } midi_state_e;

    // Program change and channel aftertouch complete after one data byte.
    function automatic logic is_one_byte(input logic [3:0] typ);
        return (typ == ST_PROG) || (typ == ST_CH_AT);
    endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// -----------------------------------------------------------------------------
// midi_msg_parser
// Turns the UART receive byte stream into decoded MIDI channel-voice events
// (note-on, note-off, control-change, pitch-bend), with running status.
//
// Parameters:
//   OMNI     1 = accept every channel, 0 = accept only CHANNEL
//   CHANNEL  channel number accepted when OMNI = 0
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   byte_valid  one-cycle strobe qualifying byte_data
//   byte_data   received byte
//   note_on     one-cycle note-on pulse
//   note_off    one-cycle note-off pulse (0x8n, or 0x9n with velocity 0)
//   cc_valid    one-cycle control-change pulse
//   bend_valid  one-cycle pitch-bend pulse
//   ev_channel  channel of the last event
//   ev_data1    note / CC number / bend LSB of the last event
//   ev_data2    velocity / CC value / bend MSB of the last event
//   bend        last pitch bend, {MSB,LSB} - 8192, two's complement
// -----------------------------------------------------------------------------
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter logic       OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        note_on,
    output logic        note_off,
    output logic        cc_valid,
    output logic        bend_valid,
    output logic [3:0]  ev_channel,
    output logic [6:0]  ev_data1,
    output logic [6:0]  ev_data2,
    output logic [13:0] bend
);

    midi_state_e state_q, state_d;
    logic        rs_valid_q, rs_valid_d;
    logic [3:0]  rs_type_q, rs_type_d;
    logic [3:0]  rs_chan_q, rs_chan_d;
    logic [6:0]  d1_q, d1_d;

    logic        note_on_q, note_on_d;
    logic        note_off_q, note_off_d;
    logic        cc_valid_q, cc_valid_d;
    logic        bend_valid_q, bend_valid_d;
    logic [3:0]  ev_channel_q, ev_channel_d;
    logic [6:0]  ev_data1_q, ev_data1_d;
    logic [6:0]  ev_data2_q, ev_data2_d;
    logic [13:0] bend_q, bend_d;

    logic        chan_ok;
    logic        ev_upd;

    assign chan_ok = OMNI || (rs_chan_q == CHANNEL);

    always_comb begin
        state_d      = state_q;
        rs_valid_d   = rs_valid_q;
        rs_type_d    = rs_type_q;
        rs_chan_d    = rs_chan_q;
        d1_d         = d1_q;
        note_on_d    = 1'b0;
        note_off_d   = 1'b0;
        cc_valid_d   = 1'b0;
        bend_valid_d = 1'b0;
        ev_channel_d = ev_channel_q;
        ev_data1_d   = ev_data1_q;
        ev_data2_d   = ev_data2_q;
        bend_d       = bend_q;
        ev_upd       = 1'b0;

        if (byte_valid) begin
            if (byte_data[7:3] == 5'b11111) begin
                // Realtime bytes may interleave anywhere; leave everything as is.
            end else if (byte_data[7:4] == 4'hF) begin
                // System common / SysEx: data that follows belongs to no channel.
                rs_valid_d = 1'b0;
                state_d    = WAIT_STATUS;
            end else if (byte_data[7]) begin
                rs_valid_d = 1'b1;
                rs_type_d  = byte_data[7:4];
                rs_chan_d  = byte_data[3:0];
                state_d    = WAIT_D1;
            end else begin
                unique case (state_q)
                    // WAIT_STATUS with running status behaves as WAIT_D1.
                    WAIT_STATUS, WAIT_D1: begin
                        if (rs_valid_q) begin
                            d1_d    = byte_data[6:0];
                            state_d = is_one_byte(rs_type_q) ? WAIT_STATUS : WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        state_d = WAIT_STATUS;
                        if (chan_ok) begin
                            case (rs_type_q)
                                ST_NOTE_ON: begin
                                    if (byte_data[6:0] != 7'd0) note_on_d = 1'b1;
                                    else                        note_off_d = 1'b1;
                                    ev_upd = 1'b1;
                                end
                                ST_NOTE_OFF: begin
                                    note_off_d = 1'b1;
                                    ev_upd     = 1'b1;
                                end
                                ST_CC: begin
                                    cc_valid_d = 1'b1;
                                    ev_upd     = 1'b1;
                                end
                                ST_BEND: begin
                                    bend_valid_d = 1'b1;
                                    ev_upd       = 1'b1;
                                    // Only pitch-bend events move the bend value.
                                    bend_d       = {byte_data[6:0], d1_q} - BEND_CENTER;
                                end
                                ST_POLY_AT: begin
                                    // Parsed for running status, produces no event.
                                end
                                default: begin
                                end
                            endcase
                        end
                        if (ev_upd) begin
                            ev_channel_d = rs_chan_q;
                            ev_data1_d   = d1_q;
                            ev_data2_d   = byte_data[6:0];
                        end
                    end
                    default: state_d = WAIT_STATUS;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_STATUS;
            rs_valid_q   <= 1'b0;
            rs_type_q    <= 4'd0;
            rs_chan_q    <= 4'd0;
            d1_q         <= 7'd0;
            note_on_q    <= 1'b0;
            note_off_q   <= 1'b0;
            cc_valid_q   <= 1'b0;
            bend_valid_q <= 1'b0;
            ev_channel_q <= 4'd0;
            ev_data1_q   <= 7'd0;
            ev_data2_q   <= 7'd0;
            bend_q       <= 14'd0;
        end else begin
            state_q      <= state_d;
            rs_valid_q   <= rs_valid_d;
            rs_type_q    <= rs_type_d;
            rs_chan_q    <= rs_chan_d;
            d1_q         <= d1_d;
            note_on_q    <= note_on_d;
            note_off_q   <= note_off_d;
            cc_valid_q   <= cc_valid_d;
            bend_valid_q <= bend_valid_d;
            ev_channel_q <= ev_channel_d;
            ev_data1_q   <= ev_data1_d;
            ev_data2_q   <= ev_data2_d;
            bend_q       <= bend_d;
        end
    end

    assign note_on    = note_on_q;
    assign note_off   = note_off_q;
    assign cc_valid   = cc_valid_q;
    assign bend_valid = bend_valid_q;
    assign ev_channel = ev_channel_q;
    assign ev_data1   = ev_data1_q;
    assign ev_data2   = ev_data2_q;
    assign bend       = bend_q;

endmodule
